// File: rtl/dvsd_mul_pkg.sv
// dvsd_mul_pkg: shared sizes, requester id type and the round-robin pick
package dvsd_mul_pkg;
   localparam int NREQ = 4;
   localparam int W = 8;
   localparam int PW = 2 * W;
   typedef logic [1:0] id_t;
   // lowest offset from p wins because it is assigned last
   function automatic id_t rr_pick(input logic [NREQ-1:0] v, input id_t p);
      id_t g;
      g = p;
      for (int i = NREQ - 1; i >= 0; i--)
         if (v[p + id_t'(i)]) g = p + id_t'(i);
      return g;
   endfunction
endpackage

// File: rtl/dvsd_mul_arb4_if.sv
// dvsd_mul_arb4_if: per-requester operand/ready lanes plus the shared product response channel
interface dvsd_mul_arb4_if #(
   parameter int NREQ = dvsd_mul_pkg::NREQ,
   parameter int W = dvsd_mul_pkg::W
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic rsp_valid;
   logic rsp_ready;
   dvsd_mul_pkg::id_t rsp_id;
   logic [2*W-1:0] rsp_m;
   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input req_ready, rsp_valid, rsp_id, rsp_m
   );
   modport slave (
      input req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_m
   );
endinterface

// File: rtl/dvsd_mul8_pipe.sv
// dvsd_mul8_pipe: two-stage unsigned multiplier; stage 1 holds operands, stage 2 holds the product
module dvsd_mul8_pipe #(
   parameter int W = dvsd_mul_pkg::W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic adv,
   input  logic in_v,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  dvsd_mul_pkg::id_t in_id,
   output logic en1,
   output logic v1,
   output logic out_v,
   output logic [2*W-1:0] out_m,
   output dvsd_mul_pkg::id_t out_id
);
   import dvsd_mul_pkg::*;
   localparam int MW = 2 * W;
   logic v1_q, v1_d, v2_q, v2_d, ld1, ld2;
   logic [W-1:0] a_q, a_d, b_q, b_d;
   id_t id1_q, id1_d, id2_q, id2_d;
   logic [MW-1:0] m_q, m_d;
   always_comb begin
      en1 = !v1_q | adv;
      ld1 = en1 & in_v;
      ld2 = adv & v1_q;
      v1_d = en1 ? in_v : v1_q;
      a_d = ld1 ? in_a : a_q;
      b_d = ld1 ? in_b : b_q;
      id1_d = ld1 ? in_id : id1_q;
      v2_d = adv ? v1_q : v2_q;
      m_d = ld2 ? MW'(a_q) * MW'(b_q) : m_q;
      id2_d = ld2 ? id1_q : id2_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         id1_q <= '0;
         id2_q <= '0;
         m_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         a_q <= a_d;
         b_q <= b_d;
         id1_q <= id1_d;
         id2_q <= id2_d;
         m_q <= m_d;
      end
   end
   assign v1 = v1_q;
   assign out_v = v2_q;
   assign out_m = m_q;
   assign out_id = id2_q;
endmodule

// File: rtl/dvsd_mul_arb4.sv
// dvsd_mul_arb4: round-robin arbiter sharing one pipelined 8x8 multiplier among four requesters
module dvsd_mul_arb4 #(
   parameter int NREQ = dvsd_mul_pkg::NREQ,
   parameter int W = dvsd_mul_pkg::W
) (
   input  logic clk,
   input  logic rst_n,
   dvsd_mul_arb4_if.slave bus,
   output logic busy
);
   import dvsd_mul_pkg::*;
   id_t ptr_q, ptr_d, gnt;
   logic adv, en1, v1, acc;
   logic [W-1:0] ga, gb;
   assign adv = !bus.rsp_valid | bus.rsp_ready;
   assign busy = v1 | bus.rsp_valid;
   // rst_n gates the strobe so nothing is offered while reset is held
   always_comb begin
      gnt = rr_pick(bus.req_valid, ptr_q);
      acc = rst_n & (|bus.req_valid) & en1;
      bus.req_ready = '0;
      bus.req_ready[gnt] = acc;
      ga = bus.req_a[gnt*W +: W];
      gb = bus.req_b[gnt*W +: W];
      ptr_d = acc ? gnt + id_t'(1) : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
   dvsd_mul8_pipe #(.W(W)) u_pipe (
      .clk(clk),
      .rst_n(rst_n),
      .adv(adv),
      .in_v(acc),
      .in_a(ga),
      .in_b(gb),
      .in_id(gnt),
      .en1(en1),
      .v1(v1),
      .out_v(bus.rsp_valid),
      .out_m(bus.rsp_m),
      .out_id(bus.rsp_id)
   );
endmodule

// File: tb/tb_dvsd_mul_arb4.sv
// tb_dvsd_mul_arb4: scenario tasks checked against an in-order queue model of the shared multiplier
module tb_dvsd_mul_arb4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int n_cmp = 0;
   int n_bad = 0;
   int ptr_m = 0;
   typedef struct {
      logic [1:0] id;
      logic [15:0] m;
      bit out;
   } ent_t;
   ent_t q[$];
   dvsd_mul_arb4_if bus ();
   dvsd_mul_arb4 dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
   always #5 clk = ~clk;
   function automatic int pick();
      for (int k = 0; k < 4; k++)
         if (bus.req_valid[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
      return -1;
   endfunction
   // two entries in flight with the consumer stalled is the only state that blocks an accept
   function automatic logic [3:0] exp_ready();
      int g = pick();
      if (!rst_n || g < 0 || (q.size() == 2 && !bus.rsp_ready)) return 4'b0000;
      return 4'b0001 << g;
   endfunction
   function automatic logic head_out();
      return (q.size() > 0) ? logic'(q[0].out) : 1'b0;
   endfunction
   task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input logic rr);
      bus.req_valid = v;
      bus.req_a = a;
      bus.req_b = b;
      bus.rsp_ready = rr;
   endtask
   task automatic model_edge();
      logic [3:0] r;
      int g;
      ent_t e;
      r = exp_ready();
      g = pick();
      if (q.size() > 0 && q[0].out && bus.rsp_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].out) begin
         e = q[0];
         e.out = 1'b1;
         q[0] = e;
      end
      if (r != 4'b0000) begin
         e.id = 2'(g);
         e.m = 16'(bus.req_a[g*8 +: 8]) * 16'(bus.req_b[g*8 +: 8]);
         e.out = 1'b0;
         q.push_back(e);
         ptr_m = (g + 1) % 4;
      end
      @(posedge clk);
   endtask
   task automatic test_reset();
      drive(4'hF, 32'h0C0D_0E0F, 32'h0102_0304, 1'b1);
      @(negedge clk);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_m !== 16'd0) begin n_bad++; $display("FAIL reset_rsp_m got=%0d exp=0", bus.rsp_m); end
      @(negedge clk);
      drive(4'h0, 32'h0, 32'h0, 1'b1);
      rst_n = 1'b1;
      q.delete();
      ptr_m = 0;
      #1;
      model_edge();
   endtask
   task automatic test_single();
      @(negedge clk);
      drive(4'b0001, 32'd12, 32'd13, 1'b1);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
      model_edge();
      @(negedge clk);
      drive(4'b0000, 32'd0, 32'd0, 1'b1);
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
      model_edge();
      @(negedge clk);
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_m !== 16'd156) begin n_bad++; $display("FAIL single_m got=%0d exp=156", bus.rsp_m); end
      n_cmp++; if (bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL single_id got=%0d exp=0", bus.rsp_id); end
      model_edge();
   endtask
   task automatic test_boundary();
      logic [7:0] ba [3] = '{8'd255, 8'd0, 8'd1};
      logic [7:0] bb [3] = '{8'd255, 8'd200, 8'd255};
      logic [15:0] bm [3] = '{16'd65025, 16'd0, 16'd255};
      logic [31:0] av, bv;
      for (int k = 0; k < 3; k++) begin
         av = $urandom;
         bv = $urandom;
         av[(k+1)*8 +: 8] = ba[k];
         bv[(k+1)*8 +: 8] = bb[k];
         @(negedge clk);
         drive(4'b0001 << (k + 1), av, bv, 1'b1);
         #1;
         n_cmp++; if (bus.req_ready !== 4'(4'b0001 << (k + 1))) begin n_bad++; $display("FAIL bound_ready k=%0d got=%b", k, bus.req_ready); end
         model_edge();
         @(negedge clk);
         drive(4'b0000, $urandom, $urandom, 1'b1);
         #1;
         model_edge();
         @(negedge clk);
         #1;
         n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_m !== bm[k]) begin n_bad++; $display("FAIL bound_m k=%0d got=%0d/%b exp=%0d", k, bus.rsp_m, bus.rsp_valid, bm[k]); end
         n_cmp++; if (bus.rsp_id !== 2'(k + 1)) begin n_bad++; $display("FAIL bound_id k=%0d got=%0d exp=%0d", k, bus.rsp_id, k + 1); end
         model_edge();
      end
   endtask
   task automatic test_back_to_back();
      @(negedge clk);
      drive(4'h0, 32'h0, 32'h0, 1'b1);
      rst_n = 1'b0;
      q.delete();
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      model_edge();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < 10) drive(4'hF, $urandom, $urandom, 1'b1);
         else drive(4'h0, $urandom, $urandom, 1'b1);
         #1;
         if (k < 10) begin
            n_cmp++; if (bus.req_ready !== 4'(4'b0001 << (k % 4))) begin n_bad++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, bus.req_ready, 4'(4'b0001 << (k % 4))); end
         end
         n_cmp++; if (bus.rsp_valid !== (k >= 2)) begin n_bad++; $display("FAIL b2b_valid k=%0d got=%b", k, bus.rsp_valid); end
         if (k >= 2) begin
            n_cmp++; if (bus.rsp_id !== 2'((k - 2) % 4) || bus.rsp_m !== q[0].m) begin n_bad++; $display("FAIL b2b_rsp k=%0d got=%0d/%0d exp=%0d/%0d", k, bus.rsp_id, bus.rsp_m, (k - 2) % 4, q[0].m); end
         end
         model_edge();
      end
   endtask
   task automatic test_stall();
      int ntx = 0;
      logic [17:0] held = '0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         drive((k < 5) ? 4'hF : 4'h0, $urandom, $urandom, !(k >= 2 && k <= 4));
         #1;
         if (k == 2) held = {q[0].id, q[0].m};
         if (k >= 2 && k <= 4) begin
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready k=%0d got=%b exp=0000", k, bus.req_ready); end
            n_cmp++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_m} !== held) begin n_bad++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, {bus.rsp_id, bus.rsp_m}, held); end
         end else begin
            n_cmp++; if (bus.req_ready !== exp_ready()) begin n_bad++; $display("FAIL stall_model_ready k=%0d got=%b exp=%b", k, bus.req_ready, exp_ready()); end
            n_cmp++; if (bus.rsp_valid !== head_out() || (head_out() && {bus.rsp_id, bus.rsp_m} !== {q[0].id, q[0].m})) begin n_bad++; $display("FAIL stall_rsp k=%0d got=%b/%h", k, bus.rsp_valid, {bus.rsp_id, bus.rsp_m}); end
         end
         if (bus.rsp_valid && bus.rsp_ready) ntx++;
         model_edge();
      end
      n_cmp++; if (ntx !== 2) begin n_bad++; $display("FAIL stall_count got=%0d exp=2", ntx); end
   endtask
   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(4'hF, $urandom, $urandom, 1'b0);
         #1;
         model_edge();
      end
      @(negedge clk);
      drive(4'hF, $urandom, $urandom, 1'b0);
      #1;
      n_cmp++; if (busy !== 1'b1 || q.size() != 2) begin n_bad++; $display("FAIL mid_preload busy=%b model=%0d", busy, q.size()); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready got=%b exp=0000", bus.req_ready); end
      q.delete();
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'hF, $urandom, $urandom, 1'b1);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); end
      model_edge();
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         drive(4'h0, $urandom, $urandom, 1'b1);
         #1;
         n_cmp++; if (bus.rsp_valid !== (j == 1)) begin n_bad++; $display("FAIL mid_stale j=%0d got=%b", j, bus.rsp_valid); end
         if (j == 1) begin
            n_cmp++; if (bus.rsp_id !== 2'd0 || bus.rsp_m !== q[0].m) begin n_bad++; $display("FAIL mid_rsp got=%0d/%0d exp=0/%0d", bus.rsp_id, bus.rsp_m, q[0].m); end
         end
         model_edge();
      end
   endtask
   task automatic test_random();
      logic [3:0] er;
      logic ev;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         drive(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
         #1;
         er = exp_ready();
         ev = head_out();
         n_cmp++; if (bus.req_ready !== er) begin n_bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, bus.req_ready, er); end
         n_cmp++; if (bus.rsp_valid !== ev) begin n_bad++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, bus.rsp_valid, ev); end
         if (ev) begin
            n_cmp++; if ({bus.rsp_id, bus.rsp_m} !== {q[0].id, q[0].m}) begin n_bad++; $display("FAIL rand_rsp i=%0d got=%0d/%0d exp=%0d/%0d", i, bus.rsp_id, bus.rsp_m, q[0].id, q[0].m); end
         end
         n_cmp++; if (busy !== (q.size() > 0)) begin n_bad++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, q.size() > 0); end
         model_edge();
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dvsd_mul_arb4.md
DVSD_MUL_ARB4 -- requirements
Module: dvsd_mul_arb4

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; only 4 is supported.
REQ-002 Parameter W, default 8, operand width; product width is 2*W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_a  input  NREQ*W  operand A, requester i in bits [i*W +: W].
REQ-007 req_b  input  NREQ*W  operand B, same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot-or-zero accept strobe per requester.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_id  output  2  index of requester that owns rsp_m.
REQ-011 rsp_m  output  2*W  unsigned product A*B.
REQ-012 rsp_ready  input  1  downstream accepts result.
REQ-013 busy  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-014 Block SHALL share one 2-stage pipelined unsigned 8x8 multiplier among NREQ requesters.
REQ-015 Transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high; rsp transfer where rsp_valid and rsp_ready are both high.
REQ-016 advance = !rsp_valid | rsp_ready; stage-2 (output) register SHALL load from stage 1 only when advance.
REQ-017 en1 = !v1 | advance (v1 = stage-1 valid); stage 1 SHALL accept a new request only when en1.
REQ-018 Grant SHALL be round-robin: first i with req_valid[i] high, searching ptr, ptr+1, ... mod 4.
REQ-019 req_ready SHALL be combinational: req_ready[g]=en1 for granted g, all other bits 0; zero when no req_valid.
REQ-020 req_ready SHALL NOT depend on req_a/req_b.
REQ-021 On an accept of requester g, ptr SHALL become (g+1) mod 4 at the next edge; unchanged otherwise.
REQ-022 Latency: request accepted at edge k SHALL present rsp_valid with its result after edge k+2 when no stall.
REQ-023 Sustained throughput SHALL be one result per cycle while rsp_ready stays high.
REQ-024 rsp_m SHALL be the full 16-bit unsigned product; no truncation, no rounding; 255*255 = 65025.
REQ-025 While rsp_valid & !rsp_ready, rsp_m and rsp_id SHALL hold stable and no request is lost or duplicated; at most 2 entries in flight.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 rsp_m/rsp_id SHALL be don't-care but deterministic when rsp_valid is low.
REQ-028 busy = v1 | rsp_valid.

Reset
REQ-029 rst_n low SHALL immediately clear v1, rsp_valid, busy, req_ready, ptr (=0), rsp_id (=0), rsp_m (=0).
REQ-030 Reset mid-operation SHALL discard in-flight entries without emitting them.
REQ-031 First accept after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-032 Shared package dvsd_mul_pkg SHALL hold NREQ, W, the id type (2 bits) and the product width constant.
REQ-033 Multiplier datapath SHALL be one sub-module dvsd_mul8_pipe (operands + id + valid in, product + id + valid out, enable input); arbitration and handshake stay in the top.

Verification
REQ-034 Single req: req_valid=0001, A=12, B=13 -> accept cycle 0, rsp_valid after edge 2, rsp_m=156, rsp_id=0.
REQ-035 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one rsp per cycle, ids in same order.
REQ-036 Boundaries: 255*255 -> 65025; 0*200 -> 0; 1*255 -> 255.
REQ-037 rsp_ready low 3 cycles with 2 entries in flight -> rsp_m/rsp_id frozen, req_ready=0000, no loss after release.
REQ-038 rst_n pulsed low with 2 in flight -> rsp_valid=0, busy=0 immediately, no stale rsp after release, next grant starts at requester 0.
